// File: rtl/bin2bcd_stream_converter_if.sv
`timescale 1ns/1ps
// Valid/ready bundle between a binary producer and the BCD converter.
// The digit count is derived here too so both ends agree on field widths.
interface bin2bcd_stream_converter_if #(
  parameter int WIDTH = 16
);
  function automatic int calc_num_digits(input int w);
    logic [127:0] limit;
    logic [127:0] pow;
    int n;
    limit = (128'd1 << w) - 128'd1;
    pow = 128'd1;
    n = 0;
    while (pow <= limit) begin
      pow = pow * 128'd10;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int NUM_DIGITS = calc_num_digits(WIDTH);
  localparam int NDW = $clog2(NUM_DIGITS + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] out_bcd;
  logic                    out_sign;
  logic [NDW-1:0]          out_ndigits;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_sign, out_ndigits
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_sign, out_ndigits
  );
endinterface

// File: rtl/bin2bcd_stream_converter.sv
`timescale 1ns/1ps
// Double-dabble binary-to-BCD converter, BITS_PER_CYCLE bits per clock,
// optional two's-complement input and a one-deep output buffer.
module bin2bcd_stream_converter #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 0
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_stream_converter_if.slave bus
);
  function automatic int calc_num_digits(input int w);
    logic [127:0] limit;
    logic [127:0] pow;
    int n;
    limit = (128'd1 << w) - 128'd1;
    pow = 128'd1;
    n = 0;
    while (pow <= limit) begin
      pow = pow * 128'd10;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int NUM_DIGITS = calc_num_digits(WIDTH);
  localparam int STEPS      = WIDTH / BITS_PER_CYCLE;
  localparam int STEP_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int NDW        = $clog2(NUM_DIGITS + 1);
  localparam int BCD_W      = 4 * NUM_DIGITS;

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $fatal(1, "bin2bcd_stream_converter: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONVERT, WAIT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_nxt, bin_t, mag;
  logic [BCD_W-1:0]  bcd_q, bcd_nxt, bcd_t, load_bcd, out_bcd_q;
  logic [STEP_W-1:0] step_q;
  logic [NDW-1:0]    load_nd, out_nd_q;
  logic              sign_q, in_neg, out_sign_q, out_valid_q;
  logic              capture, load_out, last_step, digits_ok;

  // The most negative input negates to itself, which read unsigned is exactly its magnitude.
  assign in_neg    = (SIGNED != 0) && bus.in_data[WIDTH-1];
  assign mag       = in_neg ? (WIDTH'(0) - bus.in_data) : bus.in_data;
  assign last_step = (step_q == STEP_W'(STEPS - 1));

  always_comb begin
    bin_t = bin_q;
    bcd_t = bcd_q;
    for (int s = 0; s < BITS_PER_CYCLE; s++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (bcd_t[4*d +: 4] >= 4'd5) bcd_t[4*d +: 4] = bcd_t[4*d +: 4] + 4'd3;
      end
      {bcd_t, bin_t} = {bcd_t, bin_t} << 1;
    end
    bin_nxt = bin_t;
    bcd_nxt = bcd_t;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (last_step) begin
          if (!out_valid_q || bus.out_ready) begin
            load_out = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!out_valid_q || bus.out_ready) begin
          load_out = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In WAIT the finished digits already sit in bcd_q; otherwise take this cycle's last step.
  always_comb begin
    load_bcd = (state_q == WAIT) ? bcd_q : bcd_nxt;
    load_nd  = NDW'(1);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (load_bcd[4*d +: 4] != 4'd0) load_nd = NDW'(d + 1);
    end
  end

  always_comb begin
    digits_ok = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (out_bcd_q[4*d +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
      step_q <= '0;
    end else if (capture) begin
      bin_q  <= mag;
      bcd_q  <= '0;
      sign_q <= in_neg;
      step_q <= '0;
    end else if (state_q == CONVERT) begin
      bin_q  <= bin_nxt;
      bcd_q  <= bcd_nxt;
      step_q <= step_q + STEP_W'(1);
    end
  end

  // A new result may replace one being handed off on the same edge, keeping out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_sign_q  <= 1'b0;
      out_nd_q    <= NDW'(1);
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_bcd_q   <= load_bcd;
      out_sign_q  <= sign_q;
      out_nd_q    <= load_nd;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_bcd     = out_bcd_q;
  assign bus.out_sign    = out_sign_q;
  assign bus.out_ndigits = out_nd_q;

  a_digits_valid: assert property (@(posedge clk) disable iff (!rst_n) out_valid_q |-> digits_ok);
endmodule

// File: tb/tb_bin2bcd_stream_converter.sv
`timescale 1ns/1ps
// Scoreboard bench: drivers push expected results, per-DUT monitors pop on each output transfer.
module tb_bin2bcd_stream_converter;
  typedef struct packed {
    logic        sign;
    logic [2:0]  nd;
    logic [19:0] bcd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_main;
  int   errors = 0;
  int   checks = 0;
  exp_t m_q[$];
  exp_t s_q[$];
  exp_t e_m, e_s;

  always #5 clk = ~clk;

  bin2bcd_stream_converter_if #(.WIDTH(16)) m_if();
  bin2bcd_stream_converter_if #(.WIDTH(16)) s_if();

  bin2bcd_stream_converter #(.WIDTH(16), .BITS_PER_CYCLE(1), .SIGNED(0)) u_main (
    .clk(clk), .rst_n(rst_n_main), .bus(m_if.slave)
  );
  bin2bcd_stream_converter #(.WIDTH(16), .BITS_PER_CYCLE(1), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout or unexpected event, expected normal handshake", name);
  endtask

  // Decimal reference: repeated divide by ten, independent of the shift-and-add datapath.
  function automatic exp_t model(input int unsigned mag, input logic sgn);
    exp_t e;
    int unsigned v;
    v = mag;
    e.sign = sgn;
    e.bcd  = '0;
    e.nd   = 3'd1;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      if ((v % 10) != 0) e.nd = 3'(i + 1);
      v = v / 10;
    end
    return e;
  endfunction

  task automatic applyStimulus(input int which, input logic [15:0] v);
    int t;
    if (which == 0) begin m_if.in_valid = 1'b1; m_if.in_data = v; end
    else            begin s_if.in_valid = 1'b1; s_if.in_data = v; end
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if ((which == 0) ? m_if.in_ready : s_if.in_ready) break;
      t++;
    end
    if (t == 200) fail("send_timeout");
    @(posedge clk);
    #1;
    if (which == 0) m_if.in_valid = 1'b0;
    else            s_if.in_valid = 1'b0;
  endtask

  task automatic drain(input int which);
    int t;
    t = 0;
    while (((which == 0) ? m_q.size() : s_q.size()) != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t == 500) fail("drain_timeout");
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n_main && m_if.out_valid && m_if.out_ready) begin
      if (m_q.size() == 0) fail("main_unexpected_output");
      else begin
        e_m = m_q.pop_front();
        check("main_bcd", 32'(m_if.out_bcd), 32'(e_m.bcd));
        check("main_ndigits", 32'(m_if.out_ndigits), 32'(e_m.nd));
        check("main_sign", 32'(m_if.out_sign), 32'(e_m.sign));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_if.out_valid && s_if.out_ready) begin
      if (s_q.size() == 0) fail("signed_unexpected_output");
      else begin
        e_s = s_q.pop_front();
        check("signed_bcd", 32'(s_if.out_bcd), 32'(e_s.bcd));
        check("signed_ndigits", 32'(s_if.out_ndigits), 32'(e_s.nd));
        check("signed_sign", 32'(s_if.out_sign), 32'(e_s.sign));
      end
    end
  end

  // One converter per radix; each runs a directed 9999 then a random sweep under random backpressure.
  for (genvar g = 0; g < 4; g++) begin : gen_sw
    localparam int BPC   = 1 << g;
    localparam int STEPS = 16 / BPC;
    bin2bcd_stream_converter_if #(.WIDTH(16)) w_if();
    bin2bcd_stream_converter #(.WIDTH(16), .BITS_PER_CYCLE(BPC), .SIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(w_if.slave)
    );
    exp_t q[$];
    exp_t e;
    bit   done = 1'b0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) begin
      #1;
      w_if.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
      if (rst_n && w_if.out_valid && w_if.out_ready) begin
        if (q.size() == 0) fail($sformatf("bpc%0d_unexpected_output", BPC));
        else begin
          e = q.pop_front();
          check($sformatf("bpc%0d_bcd", BPC), 32'(w_if.out_bcd), 32'(e.bcd));
          check($sformatf("bpc%0d_ndigits", BPC), 32'(w_if.out_ndigits), 32'(e.nd));
        end
      end
    end

    initial begin
      int lat;
      int t;
      logic [15:0] v;
      w_if.in_valid = 1'b0;
      w_if.in_data  = '0;
      @(posedge rst_n);
      repeat (2) @(posedge clk);
      #1;
      q.push_back(exp_t'({1'b0, 3'd4, 20'h09999}));
      w_if.in_valid = 1'b1;
      w_if.in_data  = 16'd9999;
      @(posedge clk);
      #1;
      w_if.in_valid = 1'b0;
      lat = 0;
      while (!w_if.out_valid && lat < 64) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("bpc%0d_latency", BPC), 32'(lat), 32'(STEPS));
      rand_ready = 1'b1;
      repeat (150) begin
        v = 16'($urandom_range(0, 65535));
        q.push_back(model(32'(v), 1'b0));
        w_if.in_valid = 1'b1;
        w_if.in_data  = v;
        t = 0;
        while (t < 200) begin
          @(negedge clk);
          if (w_if.in_ready) break;
          t++;
        end
        if (t == 200) fail($sformatf("bpc%0d_send_timeout", BPC));
        @(posedge clk);
        #1;
        w_if.in_valid = 1'b0;
      end
      t = 0;
      while (q.size() != 0 && t < 1000) begin
        @(posedge clk);
        t++;
      end
      if (t == 1000) fail($sformatf("bpc%0d_drain_timeout", BPC));
      done = 1'b1;
    end
  end

  initial begin
    int lat;
    int t;
    rst_n = 1'b0;
    rst_n_main = 1'b0;
    m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_n_main = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(m_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(m_if.out_valid), 32'd0);
    check("rst_out_bcd", 32'(m_if.out_bcd), 32'd0);
    check("rst_out_ndigits", 32'(m_if.out_ndigits), 32'd1);
    check("rst_out_sign", 32'(m_if.out_sign), 32'd0);
    m_if.out_ready = 1'b1;
    s_if.out_ready = 1'b1;

    m_q.push_back(exp_t'({1'b0, 3'd5, 20'h65535}));
    applyStimulus(0, 16'hFFFF);
    lat = 0;
    while (!m_if.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("main_latency", 32'(lat), 32'd16);
    drain(0);

    m_q.push_back(exp_t'({1'b0, 3'd1, 20'h00000}));
    applyStimulus(0, 16'd0);
    m_q.push_back(exp_t'({1'b0, 3'd2, 20'h00010}));
    applyStimulus(0, 16'd10);
    m_q.push_back(exp_t'({1'b0, 3'd3, 20'h00100}));
    applyStimulus(0, 16'd100);
    drain(0);

    s_q.push_back(exp_t'({1'b1, 3'd5, 20'h32768}));
    applyStimulus(1, 16'h8000);
    s_q.push_back(exp_t'({1'b1, 3'd1, 20'h00001}));
    applyStimulus(1, 16'hFFFF);
    s_q.push_back(exp_t'({1'b0, 3'd5, 20'h32767}));
    applyStimulus(1, 16'h7FFF);
    s_q.push_back(exp_t'({1'b1, 3'd2, 20'h00010}));
    applyStimulus(1, 16'hFFF6);
    drain(1);

    m_if.out_ready = 1'b0;
    m_q.push_back(exp_t'({1'b0, 3'd4, 20'h01234}));
    applyStimulus(0, 16'd1234);
    m_q.push_back(exp_t'({1'b0, 3'd4, 20'h04321}));
    applyStimulus(0, 16'd4321);
    check("bp_first_held", 32'(m_if.out_bcd), 32'h01234);
    repeat (20) @(posedge clk);
    #1;
    check("bp_valid_held", 32'(m_if.out_valid), 32'd1);
    check("bp_first_stable", 32'(m_if.out_bcd), 32'h01234);
    check("bp_stall_in_ready", 32'(m_if.in_ready), 32'd0);
    m_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_if.out_ready = 1'b0;
    check("bp_no_gap_valid", 32'(m_if.out_valid), 32'd1);
    check("bp_second_loaded", 32'(m_if.out_bcd), 32'h04321);
    check("bp_released_in_ready", 32'(m_if.in_ready), 32'd1);
    m_if.out_ready = 1'b1;
    drain(0);

    // 77 is left buffered and 999 is mid-flight when reset hits; neither is expected out.
    m_if.out_ready = 1'b0;
    applyStimulus(0, 16'd77);
    repeat (20) @(posedge clk);
    #1;
    applyStimulus(0, 16'd999);
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(m_if.out_valid), 32'd1);
    rst_n_main = 1'b0;
    #1;
    check("abort_out_valid", 32'(m_if.out_valid), 32'd0);
    check("abort_in_ready", 32'(m_if.in_ready), 32'd1);
    check("abort_out_bcd", 32'(m_if.out_bcd), 32'd0);
    @(negedge clk);
    rst_n_main = 1'b1;
    @(posedge clk);
    #1;
    m_if.out_ready = 1'b1;
    m_q.push_back(exp_t'({1'b0, 3'd2, 20'h00042}));
    applyStimulus(0, 16'd42);
    drain(0);

    t = 0;
    while (!(gen_sw[0].done && gen_sw[1].done && gen_sw[2].done && gen_sw[3].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t == 20000) fail("sweep_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
